pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register, the generalised successor of the fixed IF/ID latch. It carries an instruction/data word plus its PC between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) using a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered `up_ready_o`. A synchronous flush inserts a bubble.

## Interface
- `DATA_W`, 32: payload (instruction/data) width.
- `ADDR_W`, 32: PC width.
- `FLUSH_VALUE`, `{DATA_W{1'b0}}`: payload driven on `dn_data_o` when the stage holds a bubble.
- `CNT_W`, 16: width of the performance counters. Used only with `PIPE_STAGE_PERF_EN`.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous flush; kills all held entries.
- `up_valid_i`  in  1  upstream offers an entry.
- `up_ready_o`  out  1  stage can accept; registered, equals "skid empty".
- `up_data_i`  in  DATA_W  upstream payload.
- `up_pc_i`  in  ADDR_W  upstream PC.
- `dn_valid_o`  out  1  output entry valid.
- `dn_ready_i`  in  1  downstream consumes.
- `dn_data_o`  out  DATA_W  output payload.
- `dn_pc_o`  out  ADDR_W  output PC.
- `stall_cnt_o`  out  CNT_W  backpressure cycle count. Present only with `PIPE_STAGE_PERF_EN`.
- `flush_cnt_o`  out  CNT_W  flush cycle count. Present only with `PIPE_STAGE_PERF_EN`.

## Operation
- State consists of a main register (drives the `dn_*` outputs) and a skid register, each with a valid bit.
- Transfers:
  - Upstream accept: `acc = up_valid_i & up_ready_o`.
  - Downstream drain: `drn = dn_valid_o & dn_ready_i`.
- Priority: reset > flush > normal operation.
- Normal operation, by case:
  - Main empty, or draining (`drn`), with skid empty: on `acc` the main register loads `up_*`. With no `acc`, main valid goes to 0.
  - Main full, not draining, and `acc`: the skid register loads `up_*`.
  - Skid full and `drn`: skid moves to main and the skid empties. `up_ready_o` was 0, so no accept can occur that cycle.
  - Skid full and no `drn`: everything holds.
- Entries leave strictly in acceptance order; no entry is ever dropped or duplicated outside a flush.
- Bubble contents: whenever main valid is 0, `dn_data_o = FLUSH_VALUE` and `dn_pc_o = 0`. Payload registers load these values, so outputs are deterministic.
- Flush:
  - Both valid bits clear; main payload becomes `FLUSH_VALUE` and `dn_pc_o` becomes 0.
  - An `acc` in the flush cycle is discarded.
  - A `drn` in the flush cycle is a legal consumption of the old entry.
- Reset values: `dn_valid_o = 0`, `dn_data_o = FLUSH_VALUE`, `dn_pc_o = 0`, `up_ready_o = 1`, counters 0.

## Timing
- Latency: an accept in cycle N appears on `dn_*` in cycle N+1, or later if blocked by backpressure.
- Throughput: 1 entry/cycle while `dn_ready_i = 1`.
- `up_ready_o` depends only on registered state, with no combinational path from `dn_ready_i`. It falls the cycle after the skid fills and rises the cycle after the skid drains.
- Capacity: at most 2 entries absorbed after downstream stalls.
- `flush_i` takes effect at the next edge: `dn_valid_o = 0` and `up_ready_o = 1` in cycle N+1.
- Reset asserted mid-transfer clears the stage immediately and asynchronously; in-flight data is lost.

## Configuration
- Macro: `PIPE_STAGE_PERF_EN`.
- Defined:
  - `stall_cnt_o` increments each cycle with `dn_valid_o & ~dn_ready_i`.
  - `flush_cnt_o` increments each cycle with `flush_i = 1`.
  - Both saturate at all-ones and reset to 0; flush does not clear them.
- Undefined: counters and both ports are absent, and the remaining behaviour is identical.

## Test plan
- Streaming: `dn_ready_i = 1`, accept PCs `0x00, 0x04, 0x08` on consecutive cycles -> same PCs on `dn_pc_o` one cycle later each, `up_ready_o` held 1.
- Backpressure: `dn_ready_i = 0`, offer `A, B, C` -> A in main, B in skid, `up_ready_o = 0` from the cycle after B, C not accepted. Raise `dn_ready_i` -> A, B, C delivered in order.
- Flush with full skid: flush_i pulse -> next cycle `dn_valid_o = 0`, `dn_data_o = FLUSH_VALUE`, `dn_pc_o = 0`, `up_ready_o = 1`. The entry offered in the flush cycle never appears.
- Async reset mid-stall: `rst_ni` low between edges -> outputs take reset values immediately; after release, the first accepted entry appears one cycle later.
- With `PIPE_STAGE_PERF_EN`, `CNT_W = 4`: 20 stall cycles -> `stall_cnt_o = 0xF`; 3 flush cycles -> `flush_cnt_o = 3`.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with a 2-entry skid
// buffer. The main register drives dn_*; the skid register catches the one
// extra entry that arrives while downstream stalls. This keeps up_ready_o a
// pure register output.
// Optional feature macro: PIPE_STAGE_PERF_EN adds saturating stall and flush
// cycle counters, together with their CNT_W parameter and output ports.
module pipe_stage_skid #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [DATA_W-1:0] FLUSH_VALUE = {DATA_W{1'b0}}
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int                CNT_W       = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [ADDR_W-1:0] up_pc_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [ADDR_W-1:0] dn_pc_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [ADDR_W-1:0] main_pc;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;

    logic acc;
    logic drn;

    // The handshake is built only from registered state. There is no path
    // from dn_ready_i to up_ready_o.
    assign up_ready_o = ~skid_valid;
    assign dn_valid_o = main_valid;
    assign dn_data_o  = main_data;
    assign dn_pc_o    = main_pc;

    assign acc = up_valid_i & up_ready_o;
    assign drn = main_valid & dn_ready_i;

    // Main/skid state update: flush clears both, otherwise move entries in order
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the payload registers are reset, not just the valid bits,
            // because the bubble contents on dn_* must be deterministic.
            main_valid <= 1'b0;
            main_data  <= FLUSH_VALUE;
            main_pc    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= FLUSH_VALUE;
            skid_pc    <= '0;
        end else if (flush_i) begin
            // Any accept this cycle is discarded. A drain this cycle simply
            // consumed the old entry.
            main_valid <= 1'b0;
            main_data  <= FLUSH_VALUE;
            main_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // up_ready_o is low, so no accept can happen here.
            if (drn) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_pc    <= skid_pc;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || drn) begin
            if (acc) begin
                main_valid <= 1'b1;
                main_data  <= up_data_i;
                main_pc    <= up_pc_i;
            end else begin
                main_valid <= 1'b0;
                main_data  <= FLUSH_VALUE;
                main_pc    <= '0;
            end
        end else if (acc) begin
            // Main is held by a stalled downstream, so the new entry goes to skid.
            skid_valid <= 1'b1;
            skid_data  <= up_data_i;
            skid_pc    <= up_pc_i;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating performance counters. A flush does not clear them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (main_valid && !dn_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (flush_i && (flush_cnt_o != {CNT_W{1'b1}})) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. The reference model is an ordered
// queue of held entries, with a capacity of 2. A table of directed vectors
// carries hand-written expectations. Random traffic and async reset are
// checked against the model.
module tb_pipe_stage_skid;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam logic [31:0] FLUSH = 32'hDEAD_BEEF;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
`ifdef PIPE_STAGE_PERF_EN
    localparam int          CW    = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          up_valid;
    logic          up_ready;
    logic [DW-1:0] up_data;
    logic [AW-1:0] up_pc;
    logic          dn_valid;
    logic          dn_ready;
    logic [DW-1:0] dn_data;
    logic [AW-1:0] dn_pc;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    int            m_stall;
    int            m_flush;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] pc;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic          uv;
        logic          dr;
        logic          fl;
        logic [AW-1:0] pc;
        logic          exp_dv;
        logic          exp_ur;
        logic [AW-1:0] exp_pc;
    } vec_t;
    vec_t vecs[18];

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .FLUSH_VALUE (FLUSH)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W       (CW)
`endif
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .up_valid_i (up_valid),
        .up_ready_o (up_ready),
        .up_data_i  (up_data),
        .up_pc_i    (up_pc),
        .dn_valid_o (dn_valid),
        .dn_ready_i (dn_ready),
        .dn_data_o  (dn_data),
        .dn_pc_o    (dn_pc)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every DUT output with the model's current state.
    task automatic check_model(input string tag);
        check({tag, ".dn_valid"}, 64'(dn_valid), 64'(q.size() > 0));
        check({tag, ".up_ready"}, 64'(up_ready), 64'(q.size() < 2));
        check({tag, ".dn_pc"}, 64'(dn_pc), (q.size() > 0) ? 64'(q[0].pc) : 64'd0);
        check({tag, ".dn_data"}, 64'(dn_data), (q.size() > 0) ? 64'(q[0].data) : 64'(FLUSH));
`ifdef PIPE_STAGE_PERF_EN
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // Drive one cycle and advance the model. A drained entry is popped from
    // the scoreboard and compared with what the DUT presented.
    task automatic step(input logic uv, input logic dr, input logic fl, input logic [AW-1:0] pc);
        logic acc;
        logic drn;
        ent_t e;
        up_valid = uv;
        dn_ready = dr;
        flush    = fl;
        up_pc    = pc;
        up_data  = pc ^ KEY;
        acc = uv && (q.size() < 2);
        drn = (q.size() > 0) && dr;
        if (drn) begin
            e = q.pop_front();
            check("drain.pc", 64'(dn_pc), 64'(e.pc));
            check("drain.data", 64'(dn_data), 64'(e.data));
        end
`ifdef PIPE_STAGE_PERF_EN
        if ((dn_valid === 1'b1) && !dr && (m_stall < 15)) m_stall++;
        if (fl && (m_flush < 15)) m_flush++;
`endif
        if (fl) q.delete();
        else if (acc) q.push_back('{data: pc ^ KEY, pc: pc});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
`ifdef PIPE_STAGE_PERF_EN
        m_stall = 0;
        m_flush = 0;
`endif
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        flush    = 1'b0;
        up_valid = 1'b0;
        dn_ready = 1'b0;
        up_pc    = '0;
        up_data  = '0;
        rst_n    = 1'b1;
        #2;
        do_reset();
        check_model("reset");
        check("reset.up_ready", 64'(up_ready), 64'd1);
        check("reset.dn_data", 64'(dn_data), 64'(FLUSH));

        //                uv    dr    fl    pc       dv    ur    dn_pc
        // Streaming: the accepted PC appears on dn_pc one cycle later.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 32'h000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h004, 1'b1, 1'b1, 32'h004};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h008, 1'b1, 1'b1, 32'h008};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h000};
        // Backpressure: A goes to main, B to skid, and C is refused.
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h100};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 32'h100};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 1'b0, 32'h100};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h100};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 32'h104};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h108, 1'b1, 1'b1, 32'h108};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h000};
        // Flush with the skid full, then a flush that discards an accept.
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 1'b1, 32'h200};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h204, 1'b1, 1'b0, 32'h200};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h208, 1'b0, 1'b1, 32'h000};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h20c, 1'b0, 1'b1, 32'h000};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h000};
        // A drain in the flush cycle is a legal consumption.
        vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h300, 1'b1, 1'b1, 32'h300};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h000, 1'b0, 1'b1, 32'h000};

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].uv, vecs[i].dr, vecs[i].fl, vecs[i].pc);
            check($sformatf("vec%0d.dn_valid", i), 64'(dn_valid), 64'(vecs[i].exp_dv));
            check($sformatf("vec%0d.up_ready", i), 64'(up_ready), 64'(vecs[i].exp_ur));
            check($sformatf("vec%0d.dn_pc", i), 64'(dn_pc), 64'(vecs[i].exp_pc));
            check($sformatf("vec%0d.dn_data", i), 64'(dn_data),
                  vecs[i].exp_dv ? 64'(vecs[i].exp_pc ^ KEY) : 64'(FLUSH));
            check_model($sformatf("vec%0d", i));
        end

        // Random traffic checked against the ordered-queue model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0), 32'(1000 + 4 * i));
            check_model("rand");
        end

        // Async reset mid-stall: the outputs clear without waiting for a clock edge.
        step(1'b1, 1'b0, 1'b0, 32'h500);
        step(1'b1, 1'b0, 1'b0, 32'h504);
        check_model("pre_arst");
        #2;
        rst_n = 1'b0;
        q.delete();
`ifdef PIPE_STAGE_PERF_EN
        m_stall = 0;
        m_flush = 0;
`endif
        #1;
        check("arst.dn_valid", 64'(dn_valid), 64'd0);
        check("arst.up_ready", 64'(up_ready), 64'd1);
        check("arst.dn_pc", 64'(dn_pc), 64'd0);
        check("arst.dn_data", 64'(dn_data), 64'(FLUSH));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 32'h400);
        check("post_arst.dn_valid", 64'(dn_valid), 64'd1);
        check("post_arst.dn_pc", 64'(dn_pc), 64'h400);
        check_model("post_arst");

`ifdef PIPE_STAGE_PERF_EN
        // Counter saturation: 20 stall cycles, then 3 flush cycles.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h600);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("perf.stall_sat", 64'(stall_cnt), 64'hF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
        check("perf.flush3", 64'(flush_cnt), 64'd3);
        check_model("perf");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
